// File: rtl/fifo_pkg.sv
// Shared constants, state type and sizing helper for the symbol packer.
package fifo_pkg;

  localparam int unsigned SYM_W_DEF = 2;
  localparam int unsigned N_SYM_DEF = 4;

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } packer_state_t;

  // Width needed to hold a symbol count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_sym_packer_if.sv
// FIFO read port plus packed-word valid/ready output, bundled for the packer.
interface fifo_sym_packer_if
  import fifo_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned N_SYM = N_SYM_DEF
);

  localparam int unsigned WORD_W = SYM_W * N_SYM;
  localparam int unsigned CNT_W  = cnt_width(N_SYM);

  logic              fifo_empty;
  logic [SYM_W-1:0]  fifo_rd_data;
  logic              fifo_rd_e;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_cnt;

  // Packer side.
  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  flush,
    input  out_ready,
    output fifo_rd_e,
    output out_valid,
    output out_data,
    output out_cnt
  );

  // FIFO / downstream side.
  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output flush,
    output out_ready,
    input  fifo_rd_e,
    input  out_valid,
    input  out_data,
    input  out_cnt
  );

endinterface

// File: rtl/fifo_sym_packer.sv
// Pops narrow symbols from a FIFO and packs N_SYM of them per output word;
// flush emits a partial word tagged with its symbol count.
module fifo_sym_packer
  import fifo_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned N_SYM = N_SYM_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_sym_packer_if.master  bus
);

  localparam int unsigned WORD_W = SYM_W * N_SYM;
  localparam int unsigned CNT_W  = cnt_width(N_SYM);

  packer_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

  logic              pop;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WORD_W-1:0] asm_nxt;
  logic [SYM_W-1:0]  rd_data;

  assign rd_data = bus.fifo_rd_data;

  // Pop decision, symbol insertion and FILL/HOLD next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    asm_nxt     = asm_q;
    cnt_nxt     = cnt_q;

    // Gated by rst_n so no pop is requested while the block is held in reset.
    pop = rst_n && (state_q == FILL) && !bus.fifo_empty;

    if (pop) begin
      for (int unsigned i = 0; i < N_SYM; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          asm_nxt[i*SYM_W +: SYM_W] = rd_data;
        end
      end
      cnt_nxt = cnt_q + CNT_W'(1);
    end

    case (state_q)
      FILL: begin
        asm_d = asm_nxt;
        cnt_d = cnt_nxt;
        // Full word, or flush with at least one symbol (including this cycle's pop).
        if ((pop && (cnt_nxt == CNT_W'(N_SYM))) || (bus.flush && (cnt_nxt != '0))) begin
          out_data_d  = asm_nxt;
          out_cnt_d   = cnt_nxt;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          asm_d       = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, assembly and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign bus.fifo_rd_e = pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_fifo_sym_packer.sv
// Scoreboard bench for fifo_sym_packer: a symbol-list model predicts words,
// an independent monitor checks each word as it appears.
module tb_fifo_sym_packer;

  localparam int unsigned SYM_W  = 2;
  localparam int unsigned N_SYM  = 4;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  word_t            exp_q[$];
  logic [SYM_W-1:0] src_q[$];
  logic [SYM_W-1:0] m_syms[$];
  bit               m_hold = 1'b0;

  fifo_sym_packer_if #(.SYM_W(SYM_W), .N_SYM(N_SYM)) bus ();

  fifo_sym_packer #(.SYM_W(SYM_W), .N_SYM(N_SYM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_out(input string name, input bit v, input logic [WORD_W-1:0] d,
                            input logic [CNT_W-1:0] c);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk({name, "_data"}, 32'(bus.out_data), 32'(d));
      chk({name, "_cnt"}, 32'(bus.out_cnt), 32'(c));
    end
  endtask

  // One clock: drive inputs at negedge, check pop request, advance the model.
  task automatic step(input bit avail, input bit fl, input bit rdy);
    bit               exp_pop;
    logic [SYM_W-1:0] sym;
    word_t            w;
    @(negedge clk);
    bus.fifo_empty   = !(avail && (src_q.size() > 0));
    sym              = (src_q.size() > 0) ? src_q[0] : '0;
    bus.fifo_rd_data = sym;
    bus.flush        = fl;
    bus.out_ready    = rdy;
    #1;
    exp_pop = !m_hold && !bus.fifo_empty;
    chk("fifo_rd_e", 32'(bus.fifo_rd_e), 32'(exp_pop));
    if (m_hold) begin
      if (rdy) m_hold = 1'b0;
    end else begin
      if (exp_pop) begin
        m_syms.push_back(sym);
        sym = src_q.pop_front();
      end
      if ((m_syms.size() == N_SYM) || (fl && (m_syms.size() > 0))) begin
        w.data = '0;
        foreach (m_syms[i]) w.data = w.data | (WORD_W'(m_syms[i]) << (i * SYM_W));
        w.cnt = CNT_W'(m_syms.size());
        exp_q.push_back(w);
        m_syms.delete();
        m_hold = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: each newly presented word must match the oldest predicted word.
  initial begin : monitor
    bit    seen;
    word_t w;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && !seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got word %0h cnt %0d, expected none", bus.out_data,
                   bus.out_cnt);
        end else begin
          w = exp_q.pop_front();
          chk("sb_data", 32'(bus.out_data), 32'(w.data));
          chk("sb_cnt", 32'(bus.out_cnt), 32'(w.cnt));
        end
      end
      seen = rst_n && bus.out_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int k;
    bus.fifo_empty   = 1'b0;
    bus.fifo_rd_data = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;

    // Reset state, with a non-empty FIFO to show pops are held off.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_e", 32'(bus.fifo_rd_e), 32'(0));
    expect_out("rst", 1'b0, '0, '0);
    chk("rst_data", 32'(bus.out_data), 32'(0));
    chk("rst_cnt", 32'(bus.out_cnt), 32'(0));
    bus.fifo_empty = 1'b1;
    rst_n = 1'b1;

    // Full word 1,2,3,0, then backpressure with symbols waiting.
    src_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    repeat (4) step(1'b1, 1'b0, 1'b1);
    expect_out("word39", 1'b1, 8'h39, 3'd4);
    src_q = '{2'd3, 2'd3, 2'd2};
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0);
      expect_out("stall39", 1'b1, 8'h39, 3'd4);
    end
    step(1'b1, 1'b0, 1'b1);
    expect_out("release39", 1'b0, '0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    expect_out("flush2f", 1'b1, 8'h2F, 3'd3);
    step(1'b0, 1'b0, 1'b1);

    // Partial word 3,1 flushed with the FIFO empty.
    src_q = '{2'd3, 2'd1};
    repeat (2) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    expect_out("flush07", 1'b1, 8'h07, 3'd2);
    step(1'b0, 1'b0, 1'b1);

    // Flush coinciding with the third pop, then a flush at count 0.
    src_q = '{2'd2, 2'd2, 2'd1};
    repeat (2) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    expect_out("flush1a", 1'b1, 8'h1A, 3'd3);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    expect_out("flush_empty", 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1);

    // FIFO empty toggling every other cycle.
    src_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 7; i++) step((i % 2) == 0, 1'b0, 1'b1);
    expect_out("toggle_e4", 1'b1, 8'hE4, 3'd4);
    step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-clock after three pops.
    src_q = '{2'd1, 2'd2, 2'd3, 2'd2};
    repeat (3) step(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.fifo_empty   = 1'b0;
    bus.fifo_rd_data = src_q[0];
    bus.flush        = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_e", 32'(bus.fifo_rd_e), 32'(0));
    chk("arst_valid", 32'(bus.out_valid), 32'(0));
    m_syms.delete();
    m_hold = 1'b0;
    exp_q.delete();
    src_q.delete();
    bus.fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    src_q = '{2'd3, 2'd3, 2'd3, 2'd3};
    repeat (4) step(1'b1, 1'b0, 1'b1);
    expect_out("post_rst_ff", 1'b1, 8'hFF, 3'd4);
    step(1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 1) == 0) && (src_q.size() < 8)) begin
        src_q.push_back(SYM_W'($urandom_range(0, 3)));
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    // Drain remaining symbols and words.
    k = 0;
    while (((src_q.size() > 0) || m_hold || (m_syms.size() > 0)) && (k < 200)) begin
      step(1'b1, 1'b1, 1'b1);
      k++;
    end
    repeat (3) step(1'b0, 1'b0, 1'b1);
    chk("drain_bound", 32'(k < 200), 32'(1));
    chk("sb_all_seen", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
